// File: rtl/vdp_vram_host_write_buffer_if.sv
// ---------------------------------------------------------------------------
// vdp_vram_host_write_buffer_if
//
// Bundles the two buses of the VRAM host-write buffer:
//   host side    : host_write_en, host_register, host_write_data -> buffer
//                  host_ready, fifo_empty, overflow            <- buffer
//   arbiter side : vram_written                                 -> buffer
//                  vram_write_address_16b, vram_write_data_16b,
//                  vram_port_write_en_mask                      <- buffer
//
// Modports:
//   slave  - the write buffer itself
//   master - the environment (CPU register port plus VRAM arbiter)
// ---------------------------------------------------------------------------
interface vdp_vram_host_write_buffer_if;
    logic        host_write_en;
    logic [1:0]  host_register;
    logic [15:0] host_write_data;
    logic        host_ready;
    logic        fifo_empty;
    logic        overflow;
    logic        vram_written;
    logic [13:0] vram_write_address_16b;
    logic [15:0] vram_write_data_16b;
    logic [1:0]  vram_port_write_en_mask;

    modport slave (
        input  host_write_en,
        input  host_register,
        input  host_write_data,
        output host_ready,
        output fifo_empty,
        output overflow,
        input  vram_written,
        output vram_write_address_16b,
        output vram_write_data_16b,
        output vram_port_write_en_mask
    );

    modport master (
        output host_write_en,
        output host_register,
        output host_write_data,
        input  host_ready,
        input  fifo_empty,
        input  overflow,
        output vram_written,
        input  vram_write_address_16b,
        input  vram_write_data_16b,
        input  vram_port_write_en_mask
    );
endinterface

// File: rtl/vdp_vram_host_write_buffer.sv
// ---------------------------------------------------------------------------
// vdp_vram_host_write_buffer
//
// Buffers CPU register writes destined for VRAM. Address and increment
// writes update the running word address; each data write captures the
// current address (split into a 16-bit port address plus an even/odd port
// mask) together with the data into a small FIFO, then advances the address.
// The oldest entry is presented to the VRAM arbiter, which retires it by
// pulsing vram_written during its host write slot.
//
// Ports:
//   clk      - VDP clock
//   reset_n  - asynchronous active-low reset
//   bus      - slave modport: host register port and arbiter head port
//
// Parameter:
//   DEPTH_LOG2 - FIFO holds 2**DEPTH_LOG2 entries (1..4)
// ---------------------------------------------------------------------------
module vdp_vram_host_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    vdp_vram_host_write_buffer_if.slave    bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] REG_ADDRESS   = 2'd0;
    localparam logic [1:0] REG_INCREMENT = 2'd1;
    localparam logic [1:0] REG_DATA      = 2'd2;

    // Entry layout: {addr[13:0], mask[1:0], data[15:0]}
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [14:0]           word_addr_reg;
    logic [7:0]            increment_reg;
    logic                  overflow_reg;

    logic        full;
    logic        empty;
    logic        data_write;
    logic        push;
    logic        pop;
    logic [1:0]  push_mask;
    logic [31:0] head;

    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign data_write = bus.host_write_en && (bus.host_register == REG_DATA);
    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never makes room for a push in the same cycle.
    assign push       = data_write && !full;
    assign pop        = bus.vram_written && !empty;
    assign push_mask  = word_addr_reg[0] ? 2'b10 : 2'b01;

    // Storage holds no control state, so it needs no reset; the head
    // outputs are blanked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {word_addr_reg[14:1], push_mask, bus.host_write_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            word_addr_reg <= '0;
            increment_reg <= 8'd1;
            overflow_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (bus.host_write_en) begin
                case (bus.host_register)
                    REG_ADDRESS: begin
                        word_addr_reg <= bus.host_write_data[14:0];
                        overflow_reg  <= 1'b0;
                    end
                    REG_INCREMENT: begin
                        increment_reg <= bus.host_write_data[7:0];
                    end
                    REG_DATA: begin
                        // A dropped write leaves the address where it was so
                        // the host can retry at the same location.
                        if (full) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            word_addr_reg <= word_addr_reg + {7'd0, increment_reg};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign head = mem[rd_ptr_reg];

    assign bus.host_ready              = !full;
    assign bus.fifo_empty              = empty;
    assign bus.overflow                = overflow_reg;
    assign bus.vram_write_address_16b  = empty ? 14'd0 : head[31:18];
    assign bus.vram_port_write_en_mask = empty ? 2'b00 : head[17:16];
    assign bus.vram_write_data_16b     = empty ? 16'd0 : head[15:0];

endmodule

// File: tb/tb_vdp_vram_host_write_buffer.sv
module tb_vdp_vram_host_write_buffer;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    vdp_vram_host_write_buffer_if bus();

    vdp_vram_host_write_buffer #(.DEPTH_LOG2(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [13:0] ea,
                            input logic [1:0] em, input logic [15:0] ed);
        checks++;
        assert (bus.vram_write_address_16b === ea) else begin
            errors++;
            $error("FAIL %s.addr observed=%h expected=%h", tag, bus.vram_write_address_16b, ea);
        end
        checks++;
        assert (bus.vram_port_write_en_mask === em) else begin
            errors++;
            $error("FAIL %s.mask observed=%b expected=%b", tag, bus.vram_port_write_en_mask, em);
        end
        checks++;
        assert (bus.vram_write_data_16b === ed) else begin
            errors++;
            $error("FAIL %s.data observed=%h expected=%h", tag, bus.vram_write_data_16b, ed);
        end
        $display("check %s: addr=%h mask=%b data=%h empty=%b", tag,
                 bus.vram_write_address_16b, bus.vram_port_write_en_mask,
                 bus.vram_write_data_16b, bus.fifo_empty);
    endtask

    // Each step drives on the falling edge and returns 1 time unit after
    // the following rising edge, so results are sampled away from the edge.
    task automatic wr(input logic [1:0] r, input logic [15:0] d);
        @(negedge clk);
        bus.host_write_en   = 1'b1;
        bus.host_register   = r;
        bus.host_write_data = d;
        @(posedge clk);
        #1;
        bus.host_write_en   = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.vram_written = 1'b1;
        @(posedge clk);
        #1;
        bus.vram_written = 1'b0;
    endtask

    task automatic push_pop(input logic [15:0] d);
        @(negedge clk);
        bus.host_write_en   = 1'b1;
        bus.host_register   = 2'd2;
        bus.host_write_data = d;
        bus.vram_written    = 1'b1;
        @(posedge clk);
        #1;
        bus.host_write_en   = 1'b0;
        bus.vram_written    = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n             = 1'b0;
        bus.host_write_en   = 1'b0;
        bus.host_register   = 2'd0;
        bus.host_write_data = 16'h0000;
        bus.vram_written    = 1'b0;

        // Reset state
        #12;
        chk1("rst.host_ready", bus.host_ready, 1'b1);
        chk1("rst.fifo_empty", bus.fifo_empty, 1'b1);
        chk1("rst.overflow", bus.overflow, 1'b0);
        chk_head("rst.head", 14'h0000, 2'b00, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic sequence
        wr(2'd0, 16'h0005);
        wr(2'd1, 16'h0001);
        wr(2'd2, 16'hAAAA);
        chk1("basic.not_empty", bus.fifo_empty, 1'b0);
        chk_head("basic.first", 14'h0002, 2'b10, 16'hAAAA);
        wr(2'd2, 16'hBBBB);
        pop();
        chk_head("basic.second", 14'h0003, 2'b01, 16'hBBBB);
        pop();
        chk_head("basic.drained", 14'h0000, 2'b00, 16'h0000);
        chk1("basic.empty", bus.fifo_empty, 1'b1);

        // Overflow
        wr(2'd0, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            wr(2'd2, 16'h1000 + 16'(i));
            chk1($sformatf("ovf.ready%0d", i), bus.host_ready, (i == 3) ? 1'b0 : 1'b1);
        end
        wr(2'd2, 16'h1004);
        chk1("ovf.overflow_set", bus.overflow, 1'b1);
        chk_head("ovf.head0", 14'h0020, 2'b01, 16'h1000);
        pop();
        chk1("ovf.ready_again", bus.host_ready, 1'b1);
        chk_head("ovf.head1", 14'h0020, 2'b10, 16'h1001);
        pop();
        chk_head("ovf.head2", 14'h0021, 2'b01, 16'h1002);
        pop();
        chk_head("ovf.head3", 14'h0021, 2'b10, 16'h1003);
        pop();
        chk1("ovf.drained", bus.fifo_empty, 1'b1);
        wr(2'd2, 16'h1005);   // word_addr advanced exactly 4 times: 0x44
        chk_head("ovf.next_addr", 14'h0022, 2'b01, 16'h1005);
        chk1("ovf.still_sticky", bus.overflow, 1'b1);
        pop();
        wr(2'd0, 16'h0000);
        chk1("ovf.cleared", bus.overflow, 1'b0);

        // Address wrap
        wr(2'd0, 16'h7FFF);
        wr(2'd1, 16'h0002);
        wr(2'd2, 16'hC001);
        wr(2'd2, 16'hC002);
        chk_head("wrap.first", 14'h3FFF, 2'b10, 16'hC001);
        pop();
        chk_head("wrap.second", 14'h0000, 2'b10, 16'hC002);
        pop();
        chk1("wrap.empty", bus.fifo_empty, 1'b1);

        // Simultaneous push/pop
        wr(2'd0, 16'h0200);
        wr(2'd1, 16'h0001);
        push_pop(16'hD000);   // empty: entry must survive
        chk1("pp_empty.not_empty", bus.fifo_empty, 1'b0);
        chk_head("pp_empty.head", 14'h0100, 2'b01, 16'hD000);
        wr(2'd2, 16'hD001);
        push_pop(16'hD002);   // two entries: count stays two, order kept
        chk_head("pp_two.head", 14'h0100, 2'b10, 16'hD001);
        pop();
        chk_head("pp_two.next", 14'h0101, 2'b01, 16'hD002);
        pop();
        chk1("pp_two.empty", bus.fifo_empty, 1'b1);
        wr(2'd2, 16'hE000);
        wr(2'd2, 16'hE001);
        wr(2'd2, 16'hE002);
        wr(2'd2, 16'hE003);
        chk1("pp_full.not_ready", bus.host_ready, 1'b0);
        push_pop(16'hE004);   // full: pop happens, push rejected
        chk1("pp_full.overflow", bus.overflow, 1'b1);
        chk1("pp_full.ready", bus.host_ready, 1'b1);
        chk_head("pp_full.head1", 14'h0102, 2'b01, 16'hE001);
        pop();
        chk_head("pp_full.head2", 14'h0102, 2'b10, 16'hE002);
        pop();
        chk_head("pp_full.head3", 14'h0103, 2'b01, 16'hE003);
        pop();
        chk1("pp_full.empty", bus.fifo_empty, 1'b1);

        // Address rewrite with an entry pending
        wr(2'd0, 16'h0010);
        wr(2'd2, 16'hF00D);
        wr(2'd0, 16'h1234);
        chk_head("rewrite.head", 14'h0008, 2'b01, 16'hF00D);
        pop();
        chk1("rewrite.empty", bus.fifo_empty, 1'b1);
        wr(2'd3, 16'hFFFF);   // reserved register: no effect
        chk1("reg3.empty", bus.fifo_empty, 1'b1);

        // Reset mid-operation (increment currently 1, set to 2 first)
        wr(2'd1, 16'h0002);
        wr(2'd0, 16'h0300);
        wr(2'd2, 16'h0001);
        wr(2'd2, 16'h0002);
        wr(2'd2, 16'h0003);
        chk_head("midrst.before", 14'h0180, 2'b01, 16'h0001);
        #1;
        reset_n = 1'b0;
        #1;
        chk_head("midrst.async", 14'h0000, 2'b00, 16'h0000);
        chk1("midrst.empty", bus.fifo_empty, 1'b1);
        chk1("midrst.ready", bus.host_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        pop();
        pop();
        chk1("midrst.pop_ignored", bus.fifo_empty, 1'b1);
        chk_head("midrst.pop_head", 14'h0000, 2'b00, 16'h0000);
        wr(2'd0, 16'h0100);
        wr(2'd2, 16'h1111);
        wr(2'd2, 16'h2222);   // increment back to 1 after reset
        chk_head("midrst.inc1_a", 14'h0080, 2'b01, 16'h1111);
        pop();
        chk_head("midrst.inc1_b", 14'h0080, 2'b10, 16'h2222);
        pop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
